// File: rtl/cdb_rr_arbiter.sv
// Complete-stage arbiter: per-channel one-entry holding buffers feeding up to
// N_CDB registered common-data-bus lanes, round-robin or fixed priority.
module cdb_rr_arbiter #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned N_CDB     = 2,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic [N_CH-1:0]           in_valid,
  input  logic [N_CH*TAG_W-1:0]     in_tag,
  input  logic [N_CH*DATA_W-1:0]    in_value,
  output logic [N_CH-1:0]           in_stall,
  output logic [N_CDB-1:0]          cdb_valid,
  output logic [N_CDB*TAG_W-1:0]    cdb_tag,
  output logic [N_CDB*DATA_W-1:0]   cdb_value,
  output logic [N_CDB*3-1:0]        cdb_src,
  output logic [3:0]                busy_cnt
);

  localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned SRC_W = 3;
  localparam int unsigned CNT_W = 4;

  logic [N_CH-1:0]   hold_valid;
  logic [TAG_W-1:0]  hold_tag   [N_CH];
  logic [DATA_W-1:0] hold_value [N_CH];
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_ptr_nxt;

  logic [N_CH-1:0]   grant;
  logic [N_CH-1:0]   accept;
  logic [N_CH-1:0]   hold_valid_nxt;
  logic [CNT_W-1:0]  busy_nxt;
  logic [N_CDB-1:0]  lane_vld;
  logic [TAG_W-1:0]  lane_tag   [N_CDB];
  logic [DATA_W-1:0] lane_value [N_CDB];
  logic [SRC_W-1:0]  lane_src   [N_CDB];

  // Grant: scan occupied buffers from the start channel with wrap-around;
  // the n-th occupied buffer found is routed to lane n.
  always_comb begin
    int unsigned start_ch;
    int unsigned ch;
    int unsigned cnt;
    grant      = '0;
    lane_vld   = '0;
    rr_ptr_nxt = rr_ptr;
    cnt        = 0;
    for (int unsigned k = 0; k < N_CDB; k++) begin
      lane_tag[k]   = '0;
      lane_value[k] = '0;
      lane_src[k]   = '0;
    end
    start_ch = (PRIO_MODE != 0) ? 0 : 32'(rr_ptr);
    for (int unsigned j = 0; j < N_CH; j++) begin
      ch = (start_ch + j) % N_CH;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (i == ch && hold_valid[i] && cnt < N_CDB) begin
          grant[i] = 1'b1;
          for (int unsigned k = 0; k < N_CDB; k++) begin
            if (k == cnt) begin
              lane_vld[k]   = 1'b1;
              lane_tag[k]   = hold_tag[i];
              lane_value[k] = hold_value[i];
              lane_src[k]   = SRC_W'(i);
            end
          end
          cnt        = cnt + 1;
          rr_ptr_nxt = PTR_W'((i + 1) % N_CH);
        end
      end
    end
  end

  assign in_stall = hold_valid & ~grant;
  assign accept   = in_valid & ~in_stall;

  // Buffer occupancy after this edge; a granted buffer may reload at once.
  always_comb begin
    hold_valid_nxt = hold_valid;
    busy_nxt       = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (squash)         hold_valid_nxt[i] = 1'b0;
      else if (accept[i]) hold_valid_nxt[i] = 1'b1;
      else if (grant[i])  hold_valid_nxt[i] = 1'b0;
      busy_nxt = busy_nxt + CNT_W'(hold_valid_nxt[i]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid <= '0;
      rr_ptr     <= '0;
      busy_cnt   <= '0;
      cdb_valid  <= '0;
      cdb_tag    <= '0;
      cdb_value  <= '0;
      cdb_src    <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        hold_tag[i]   <= '0;
        hold_value[i] <= '0;
      end
    end else begin
      hold_valid <= hold_valid_nxt;
      busy_cnt   <= busy_nxt;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (!squash && accept[i]) begin
          hold_tag[i]   <= in_tag[i*TAG_W +: TAG_W];
          hold_value[i] <= in_value[i*DATA_W +: DATA_W];
        end
      end
      if (!squash && PRIO_MODE == 0) rr_ptr <= rr_ptr_nxt;
      // Idle lanes keep their last payload; only the valid bit drops.
      if (squash) begin
        cdb_valid <= '0;
      end else begin
        cdb_valid <= lane_vld;
        for (int unsigned k = 0; k < N_CDB; k++) begin
          if (lane_vld[k]) begin
            cdb_tag[k*TAG_W +: TAG_W]    <= lane_tag[k];
            cdb_value[k*DATA_W +: DATA_W] <= lane_value[k];
            cdb_src[k*SRC_W +: SRC_W]    <= lane_src[k];
          end
        end
      end
    end
  end

endmodule
